lcd_pixel_writer: RTL and testbench

- Downstream consumer of the LCD frame-buffer address generator.
- On start, it issues the 8080-parallel window-set command sequence (CASET, PASET, RAMWR) to the LCD controller.
- It then streams pix_num 16-bit pixels read from the image ROM.
- It pulses addr_inc, which drives the address generator's count enable, once per pixel consumed.

---
 rtl/lcd_pixel_writer_if.sv | 31 +++
 rtl/lcd_pixel_writer.sv | 191 +++++++++++++++++++
 tb/tb_lcd_pixel_writer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pixel_writer_if.sv
// Signal bundle between the frame controller, the image ROM path and the LCD pixel writer.
// The slave side is the writer; the master side drives requests and ROM data.
interface lcd_pixel_writer_if #(
   parameter int unsigned CNT_WIDTH = 17
) ();
   logic                 start;
   logic                 abort;
   logic [15:0]          x0;
   logic [15:0]          x1;
   logic [15:0]          y0;
   logic [15:0]          y1;
   logic [CNT_WIDTH-1:0] pix_num;
   logic [15:0]          pix_data;
   logic                 addr_inc;
   logic                 lcd_cs_n;
   logic                 lcd_rs;
   logic                 lcd_wr_n;
   logic [15:0]          lcd_data;
   logic                 busy;
   logic                 done;

   modport master (
      output start, abort, x0, x1, y0, y1, pix_num, pix_data,
      input  addr_inc, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_data, busy, done
   );

   modport slave (
      input  start, abort, x0, x1, y0, y1, pix_num, pix_data,
      output addr_inc, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_data, busy, done
   );
endinterface

// File: rtl/lcd_pixel_writer.sv
// 8080-parallel LCD writer: sends the CASET/PASET/RAMWR window sequence, then streams
// pix_num ROM pixels, pulsing addr_inc once per pixel to advance the address generator.
module lcd_pixel_writer #(
   parameter int unsigned WR_LOW    = 1,
   parameter int unsigned WR_HIGH   = 1,
   parameter int unsigned CNT_WIDTH = 17
) (
   input logic               clk,
   input logic               rstn,
   lcd_pixel_writer_if.slave bus
);
   localparam int unsigned SlotLen = WR_LOW + WR_HIGH;
   localparam int unsigned PhW     = $clog2(SlotLen);
   localparam logic [PhW-1:0] PhLast = PhW'(SlotLen - 1);
   localparam logic [PhW-1:0] PhLow  = PhW'(WR_LOW);
   localparam logic [3:0]     IdxLast = 4'd10;

   typedef enum logic [1:0] {StIdle, StCmd, StPix, StFin} state_e;

   state_e               state_q, state_d;
   logic [3:0]           idx_q, idx_d;
   logic [PhW-1:0]       ph_q, ph_d;
   logic [PhW-1:0]       ph_inc;
   logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
   logic [15:0]          x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
   logic [CNT_WIDTH-1:0] pix_num_q, pix_num_d;
   logic                 cs_n_q, cs_n_d;
   logic                 rs_q, rs_d;
   logic                 wr_n_q, wr_n_d;
   logic [15:0]          data_q, data_d;
   logic                 addr_inc_q, addr_inc_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [3:0]           cmd_idx;
   logic [15:0]          cmd_data;
   logic                 cmd_rs;

   // Word for the command slot about to start; slot 0 is a constant so it can be
   // issued on the same edge that latches the window coordinates.
   always_comb begin
      cmd_idx  = (state_q == StIdle) ? 4'd0 : idx_q + 4'd1;
      cmd_data = 16'h0000;
      case (cmd_idx)
         4'd0:    cmd_data = 16'h002A;
         4'd1:    cmd_data = {8'h00, x0_q[15:8]};
         4'd2:    cmd_data = {8'h00, x0_q[7:0]};
         4'd3:    cmd_data = {8'h00, x1_q[15:8]};
         4'd4:    cmd_data = {8'h00, x1_q[7:0]};
         4'd5:    cmd_data = 16'h002B;
         4'd6:    cmd_data = {8'h00, y0_q[15:8]};
         4'd7:    cmd_data = {8'h00, y0_q[7:0]};
         4'd8:    cmd_data = {8'h00, y1_q[15:8]};
         4'd9:    cmd_data = {8'h00, y1_q[7:0]};
         4'd10:   cmd_data = 16'h002C;
         default: cmd_data = 16'h0000;
      endcase
      cmd_rs = !((cmd_idx == 4'd0) || (cmd_idx == 4'd5) || (cmd_idx == 4'd10));
   end

   assign ph_inc = ph_q + PhW'(1);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      ph_d       = ph_q;
      pix_cnt_d  = pix_cnt_q;
      x0_d       = x0_q;
      x1_d       = x1_q;
      y0_d       = y0_q;
      y1_d       = y1_q;
      pix_num_d  = pix_num_q;
      cs_n_d     = cs_n_q;
      rs_d       = rs_q;
      wr_n_d     = wr_n_q;
      data_d     = data_q;
      addr_inc_d = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.abort) begin
               x0_d      = bus.x0;
               x1_d      = bus.x1;
               y0_d      = bus.y0;
               y1_d      = bus.y1;
               pix_num_d = bus.pix_num;
               state_d   = StCmd;
               idx_d     = 4'd0;
               ph_d      = '0;
               pix_cnt_d = '0;
               data_d    = cmd_data;
               rs_d      = cmd_rs;
               wr_n_d    = 1'b0;
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
            end
         end
         StCmd, StPix: begin
            if (bus.abort) begin
               state_d = StIdle;
               cs_n_d  = 1'b1;
               wr_n_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (ph_q != PhLast) begin
               ph_d   = ph_inc;
               wr_n_d = (ph_inc >= PhLow);
            end else begin
               ph_d = '0;
               if ((state_q == StCmd) && (idx_q != IdxLast)) begin
                  idx_d  = idx_q + 4'd1;
                  data_d = cmd_data;
                  rs_d   = cmd_rs;
                  wr_n_d = 1'b0;
               end else if (pix_cnt_q != pix_num_q) begin
                  // pix_cnt_q is still zero on leaving CMD, so this also covers pix_num == 0.
                  state_d    = StPix;
                  pix_cnt_d  = pix_cnt_q + CNT_WIDTH'(1);
                  data_d     = bus.pix_data;
                  rs_d       = 1'b1;
                  wr_n_d     = 1'b0;
                  addr_inc_d = 1'b1;
               end else begin
                  state_d = StFin;
                  cs_n_d  = 1'b1;
                  rs_d    = 1'b1;
                  wr_n_d  = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cs_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         ph_q       <= '0;
         pix_cnt_q  <= '0;
         x0_q       <= '0;
         x1_q       <= '0;
         y0_q       <= '0;
         y1_q       <= '0;
         pix_num_q  <= '0;
         cs_n_q     <= 1'b1;
         rs_q       <= 1'b1;
         wr_n_q     <= 1'b1;
         data_q     <= '0;
         addr_inc_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         ph_q       <= ph_d;
         pix_cnt_q  <= pix_cnt_d;
         x0_q       <= x0_d;
         x1_q       <= x1_d;
         y0_q       <= y0_d;
         y1_q       <= y1_d;
         pix_num_q  <= pix_num_d;
         cs_n_q     <= cs_n_d;
         rs_q       <= rs_d;
         wr_n_q     <= wr_n_d;
         data_q     <= data_d;
         addr_inc_q <= addr_inc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.addr_inc = addr_inc_q;
   assign bus.lcd_cs_n = cs_n_q;
   assign bus.lcd_rs   = rs_q;
   assign bus.lcd_wr_n = wr_n_q;
   assign bus.lcd_data = data_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_lcd_pixel_writer.sv
// Bench for lcd_pixel_writer: two timing configurations driven in parallel, each checked every
// cycle against a slot-arithmetic model, plus literal expectations for the planned scenarios.
module tb_lcd_pixel_writer;
   localparam int unsigned CW = 17;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [15:0]   x0 = '0, x1 = '0, y0 = '0, y1 = '0;
   logic [CW-1:0] pix_num = '0;

   int checks = 0;
   int errors = 0;

   int sb_busy [2];
   int sb_inc  [2];
   int sb_done [2];
   int sb_cap  [2];

   logic [15:0] lit1 [15] = '{16'h002A, 16'h0000, 16'h0010, 16'h0000, 16'h00EF, 16'h002B,
                              16'h0000, 16'h0000, 16'h0001, 16'h003F, 16'h002C, 16'h0100,
                              16'h0101, 16'h0102, 16'h0103};
   int          rs1  [15] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};

   always #5 clk = ~clk;

   task automatic chk(input int inst, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL inst%0d %s: got 0x%0h, expected 0x%0h", inst, name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int unsigned WL = (g == 0) ? 1 : 2;
      localparam int unsigned WH = (g == 0) ? 1 : 3;
      localparam int Slot = int'(WL + WH);

      lcd_pixel_writer_if #(.CNT_WIDTH(CW)) bus ();

      logic [15:0] rom_addr;
      bit          act = 1'b0;
      int          t = 0;
      int          total = 0;
      logic [15:0] w [11];
      int          busy_cnt = 0;
      int          inc_cnt = 0;
      int          done_cnt = 0;
      logic [16:0] cap_q [$];

      assign bus.start    = start;
      assign bus.abort    = abort;
      assign bus.x0       = x0;
      assign bus.x1       = x1;
      assign bus.y0       = y0;
      assign bus.y1       = y1;
      assign bus.pix_num  = pix_num;
      // Address generator plus ROM: counter advances on cnt_en, data = addr + 0x100.
      assign bus.pix_data = 16'h0100 + rom_addr;

      lcd_pixel_writer #(
         .WR_LOW(WL),
         .WR_HIGH(WH),
         .CNT_WIDTH(CW)
      ) dut (
         .clk(clk),
         .rstn(rstn),
         .bus(bus.slave)
      );

      // Transfer model: elapsed cycles since acceptance and the expected word list.
      always @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            act      <= 1'b0;
            t        <= 0;
            total    <= 0;
            rom_addr <= '0;
         end else begin
            if (bus.addr_inc === 1'b1) rom_addr <= rom_addr + 16'd1;
            if (act) begin
               if (abort || (t == total)) act <= 1'b0;
               else t <= t + 1;
            end else if (start && !abort) begin
               act      <= 1'b1;
               t        <= 0;
               total    <= (11 + int'(pix_num)) * Slot;
               rom_addr <= '0;
               w[0]     <= 16'h002A;
               w[1]     <= {8'h00, x0[15:8]};
               w[2]     <= {8'h00, x0[7:0]};
               w[3]     <= {8'h00, x1[15:8]};
               w[4]     <= {8'h00, x1[7:0]};
               w[5]     <= 16'h002B;
               w[6]     <= {8'h00, y0[15:8]};
               w[7]     <= {8'h00, y0[7:0]};
               w[8]     <= {8'h00, y1[15:8]};
               w[9]     <= {8'h00, y1[7:0]};
               w[10]    <= 16'h002C;
            end
         end
      end

      always @(negedge clk) begin : cmp
         int          slot;
         int          ph;
         logic [15:0] ed;
         logic        er;
         if (act && (t < total)) begin
            slot = t / Slot;
            ph   = t % Slot;
            ed   = (slot < 11) ? w[slot] : 16'h0100 + 16'(slot - 11);
            er   = !((slot == 0) || (slot == 5) || (slot == 10));
            chk(g, "cs_n", 32'(bus.lcd_cs_n), 0);
            chk(g, "busy", 32'(bus.busy), 1);
            chk(g, "done", 32'(bus.done), 0);
            chk(g, "wr_n", 32'(bus.lcd_wr_n), 32'(ph >= int'(WL)));
            chk(g, "addr_inc", 32'(bus.addr_inc), 32'((slot >= 11) && (ph == 0)));
            chk(g, "rs", 32'(bus.lcd_rs), 32'(er));
            chk(g, "data", 32'(bus.lcd_data), 32'(ed));
         end else if (act) begin
            chk(g, "fin cs_n", 32'(bus.lcd_cs_n), 1);
            chk(g, "fin rs", 32'(bus.lcd_rs), 1);
            chk(g, "fin wr_n", 32'(bus.lcd_wr_n), 1);
            chk(g, "fin busy", 32'(bus.busy), 0);
            chk(g, "fin done", 32'(bus.done), 1);
            chk(g, "fin addr_inc", 32'(bus.addr_inc), 0);
         end else begin
            chk(g, "idle cs_n", 32'(bus.lcd_cs_n), 1);
            chk(g, "idle wr_n", 32'(bus.lcd_wr_n), 1);
            chk(g, "idle busy", 32'(bus.busy), 0);
            chk(g, "idle done", 32'(bus.done), 0);
            chk(g, "idle addr_inc", 32'(bus.addr_inc), 0);
         end
      end

      always @(negedge clk) begin
         if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
         if (bus.addr_inc === 1'b1) inc_cnt <= inc_cnt + 1;
         if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
      end

      always @(posedge bus.lcd_wr_n) cap_q.push_back({bus.lcd_rs, bus.lcd_data});
   end

   task automatic snap();
      #1;
      sb_busy[0] = cfg[0].busy_cnt;
      sb_inc[0]  = cfg[0].inc_cnt;
      sb_done[0] = cfg[0].done_cnt;
      sb_cap[0]  = cfg[0].cap_q.size();
      sb_busy[1] = cfg[1].busy_cnt;
      sb_inc[1]  = cfg[1].inc_cnt;
      sb_done[1] = cfg[1].done_cnt;
      sb_cap[1]  = cfg[1].cap_q.size();
   endtask

   task automatic stat_chk(input int busy0, input int busy1, input int inc0, input int inc1,
                           input int done0, input int done1, input int cap0, input int cap1);
      #1;
      chk(0, "busy cycles", 32'(cfg[0].busy_cnt - sb_busy[0]), 32'(busy0));
      chk(1, "busy cycles", 32'(cfg[1].busy_cnt - sb_busy[1]), 32'(busy1));
      chk(0, "addr_inc pulses", 32'(cfg[0].inc_cnt - sb_inc[0]), 32'(inc0));
      chk(1, "addr_inc pulses", 32'(cfg[1].inc_cnt - sb_inc[1]), 32'(inc1));
      chk(0, "done pulses", 32'(cfg[0].done_cnt - sb_done[0]), 32'(done0));
      chk(1, "done pulses", 32'(cfg[1].done_cnt - sb_done[1]), 32'(done1));
      chk(0, "wr_n captures", 32'(cfg[0].cap_q.size() - sb_cap[0]), 32'(cap0));
      chk(1, "wr_n captures", 32'(cfg[1].cap_q.size() - sb_cap[1]), 32'(cap1));
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      bit ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (!cfg[0].act && !cfg[1].act) begin
            ok = 1'b1;
            break;
         end
      end
      chk(0, "transfer ends within bound", 32'(ok), 1);
   endtask

   task automatic reset_chk();
      chk(0, "rst cs_n", 32'(cfg[0].bus.lcd_cs_n), 1);
      chk(0, "rst wr_n", 32'(cfg[0].bus.lcd_wr_n), 1);
      chk(0, "rst rs", 32'(cfg[0].bus.lcd_rs), 1);
      chk(0, "rst data", 32'(cfg[0].bus.lcd_data), 0);
      chk(0, "rst addr_inc", 32'(cfg[0].bus.addr_inc), 0);
      chk(0, "rst busy", 32'(cfg[0].bus.busy), 0);
      chk(0, "rst done", 32'(cfg[0].bus.done), 0);
      chk(1, "rst cs_n", 32'(cfg[1].bus.lcd_cs_n), 1);
      chk(1, "rst wr_n", 32'(cfg[1].bus.lcd_wr_n), 1);
      chk(1, "rst rs", 32'(cfg[1].bus.lcd_rs), 1);
      chk(1, "rst data", 32'(cfg[1].bus.lcd_data), 0);
      chk(1, "rst busy", 32'(cfg[1].bus.busy), 0);
   endtask

   initial begin
      #1 rstn = 1'b0;
      #2 reset_chk();
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;

      // Default window, 4 pixels: literal capture sequence on the default-timing instance.
      x0 = 16'h0010; x1 = 16'h00EF; y0 = 16'h0000; y1 = 16'h013F; pix_num = CW'(4);
      snap();
      pulse_start();
      wait_idle(500);
      stat_chk(30, 75, 4, 4, 1, 1, 15, 15);
      for (int i = 0; i < 15; i++) begin
         logic [16:0] c;
         if (sb_cap[0] + i < cfg[0].cap_q.size()) begin
            c = cfg[0].cap_q[sb_cap[0] + i];
            chk(0, $sformatf("capture %0d data", i), 32'(c[15:0]), 32'(lit1[i]));
            chk(0, $sformatf("capture %0d rs", i), 32'(c[16]), 32'(rs1[i]));
         end
      end

      // No pixels: commands only.
      pix_num = '0;
      snap();
      pulse_start();
      wait_idle(500);
      stat_chk(22, 55, 0, 0, 1, 1, 11, 11);

      // Three pixels: wide-timing instance must stay busy 70 cycles.
      pix_num = CW'(3);
      snap();
      pulse_start();
      wait_idle(500);
      stat_chk(28, 70, 3, 3, 1, 1, 14, 14);

      // Abort during the second pixel slot of the default instance (t = 25).
      pix_num = CW'(6);
      snap();
      pulse_start();
      repeat (25) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk(0, "abort cs_n", 32'(cfg[0].bus.lcd_cs_n), 1);
      chk(0, "abort wr_n", 32'(cfg[0].bus.lcd_wr_n), 1);
      chk(0, "abort busy", 32'(cfg[0].bus.busy), 0);
      chk(1, "abort busy", 32'(cfg[1].bus.busy), 0);
      wait_idle(50);
      chk(0, "abort addr_inc pulses", 32'(cfg[0].inc_cnt - sb_inc[0]), 2);
      chk(0, "abort no done", 32'(cfg[0].done_cnt - sb_done[0]), 0);
      chk(1, "abort no done", 32'(cfg[1].done_cnt - sb_done[1]), 0);

      // Replay after abort restarts from 0x002A.
      pix_num = CW'(2);
      snap();
      pulse_start();
      wait_idle(500);
      stat_chk(26, 65, 2, 2, 1, 1, 13, 13);
      if (sb_cap[0] < cfg[0].cap_q.size())
         chk(0, "replay first word", 32'(cfg[0].cap_q[sb_cap[0]]), 32'h0_002A);
      if (sb_cap[1] < cfg[1].cap_q.size())
         chk(1, "replay first word", 32'(cfg[1].cap_q[sb_cap[1]]), 32'h0_002A);

      // start together with abort while idle is ignored.
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk(0, "start+abort ignored", 32'(cfg[0].bus.busy), 0);

      // Second start during CMD is ignored.
      snap();
      pulse_start();
      repeat (4) @(negedge clk);
      x0 = 16'hFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(500);
      stat_chk(26, 65, 2, 2, 1, 1, 13, 13);

      // Asynchronous reset mid-PIX.
      pix_num = CW'(8);
      pulse_start();
      repeat (26) @(negedge clk);
      #2 rstn = 1'b0;
      #1 reset_chk();
      @(negedge clk);
      #2 rstn = 1'b1;

      // Back-to-back: restart in the cycle after done on the default instance.
      pix_num = CW'(3);
      snap();
      pulse_start();
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cfg[0].bus.done === 1'b1) begin
               seen = 1'b1;
               break;
            end
         end
         chk(0, "done seen for back-to-back", 32'(seen), 1);
      end
      @(negedge clk);
      pix_num = CW'(5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(500);
      stat_chk(28 + 32, 70, 8, 3, 2, 1, 30, 14);

      // Randomized transfers, aborts and stray starts; the per-cycle model checks everything.
      for (int it = 0; it < 30; it++) begin
         int r;
         x0 = 16'($urandom); x1 = 16'($urandom); y0 = 16'($urandom); y1 = 16'($urandom);
         pix_num = CW'($urandom_range(0, 10));
         @(negedge clk);
         start = 1'b1;
         abort = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         x0 = 16'($urandom); x1 = 16'($urandom); y0 = 16'($urandom); y1 = 16'($urandom);
         pix_num = CW'($urandom_range(0, 10));
         r = int'($urandom_range(0, 3));
         if (r == 0) begin
            repeat ($urandom_range(0, 80)) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
         end else if (r == 1) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         wait_idle(2000);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d",
               checks, errors);
      $fatal(1);
   end
endmodule
